alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//   Shares one instance of the team's 32-bit alu between two requesters.
//   Each requester issues an operation (a, b, 2-bit op) over a valid/ready handshake.
//   An arbiter grants one requester per operation. A 3-state FSM
//   (IDLE/EXEC/RESP) latches the operands, drives the alu, and registers y/zero.
//   Results come back on a shared response port, tagged with the requester id.
//   Sits between the datapath's operation sources and the shared alu.
// PARAMETERS
//   PRIO_MODE  0   0 = round-robin on ties; 1 = fixed priority, req0 always wins
//   CNT_W      16  width of the completed-operation counter
// PORTS
//   clk         in   1      single clock, all state updates on posedge
//   rst         in   1      synchronous reset, active-high
//   req0_valid  in   1      requester 0 has an operation
//   req0_ready  out  1      requester 0 operation accepted this cycle
//   req0_a      in   32     operand a, requester 0
//   req0_b      in   32     operand b, requester 0
//   req0_op     in   2      00 AND, 01 OR, 10 ADD, 11 SUB
//   req1_valid  in   1      requester 1 has an operation
//   req1_ready  out  1      requester 1 operation accepted this cycle
//   req1_a      in   32     operand a, requester 1
//   req1_b      in   32     operand b, requester 1
//   req1_op     in   2      same encoding as req0_op
//   rsp_valid   out  1      result available
//   rsp_ready   in   1      consumer takes result
//   rsp_id      out  1      requester that issued the result
//   rsp_y       out  32     registered alu result
//   rsp_zero    out  1      registered alu zero flag (y == 0)
//   busy        out  1      1 whenever state != IDLE
//   op_count    out  CNT_W  completed responses, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset (rst=1 at posedge, overrides everything, including mid-operation):
//   - state=IDLE; rsp_valid=0, rsp_id=0, rsp_y=0, rsp_zero=0; op_count=0.
//   - last_grant=1, so req0 wins the first tie.
//   - Any in-flight operation or pending response is discarded.
// - IDLE:
//   - grant is combinational from valids.
//   - PRIO_MODE=0: if only one requester is valid, grant it. If both are valid, grant !last_grant.
//   - PRIO_MODE=1: grant req0 whenever req0_valid=1.
//   - reqN_ready = (state==IDLE) & reqN_valid & grant==N; at most one ready is high.
//   - On accept: latch a, b, op and id; update last_grant=id; go to EXEC.
// - EXEC (1 cycle): the alu is driven from the latched regs.
//   - At the clock edge: rsp_y <= alu.y, rsp_zero <= alu.zero, rsp_id <= id, rsp_valid <= 1.
//   - Then go to RESP.
// - RESP:
//   - rsp_* are held stable while rsp_valid=1 and rsp_ready=0; this wait has no timeout.
//   - On rsp_valid & rsp_ready: rsp_valid <= 0, op_count <= op_count+1, go to IDLE.
// - Latency:
//   - Accept at edge t gives rsp_valid=1 after edge t+1.
//   - If the response is taken immediately, the next accept happens at edge t+3.
//   - Peak throughput is 1 op per 3 cycles.
// - No accept in EXEC or RESP, even if rsp_ready is high in the same cycle; both readies are 0 there.
// - Arithmetic is 32-bit modulo: ADD/SUB wrap, with no carry or overflow output.
//   - rsp_zero reflects the wrapped 32-bit result only.
// - Requesters must hold valid, a, b and op until ready.
//   - Values changing after accept do not affect the in-flight op.
// - op_count wraps from all-ones to 0 with no flag.
// TESTING
// - Accept: req0 ADD a=8, b=41.
//   -> req0_ready at t; rsp_valid after t+1; rsp_y=49, rsp_zero=0, rsp_id=0; op_count=1.
// - Zero flag: req1 SUB a=41, b=41.
//   -> rsp_y=0, rsp_zero=1, rsp_id=1.
// - Wrap: SUB a=8, b=41.
//   -> rsp_y=32'hFFFFFFDF, rsp_zero=0.
// - Tie, PRIO_MODE=0: both valid continuously (r0 AND 0xF0&0x3C, r1 OR 0xF0|0x0F), rsp_ready=1.
//   -> grants alternate r0, r1, r0; results 0x30 (id 0), 0xFF (id 1); accepts 3 cycles apart.
// - Tie, PRIO_MODE=1: both valid continuously.
//   -> only req0 is granted; req1_ready stays 0.
// - Stall: rsp_ready=0 for 5 cycles.
//   -> rsp_* held stable; both readies stay 0; busy=1.
// - Mid-operation reset: rst=1 during EXEC or RESP.
//   -> next cycle state=IDLE, rsp_valid=0, op_count=0; first post-reset tie grants req0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester arbiter sharing one 32-bit AND/OR/ADD/SUB alu,
//                with a tagged, registered response port.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_y,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;

    state_t             state_q;
    logic               last_grant_q;
    logic               id_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [1:0]         op_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [31:0]        rsp_y_q;
    logic               rsp_zero_q;
    logic [CNT_W-1:0]   op_count_q;

    logic               w_grant;
    logic               w_idle;
    logic               w_accept;
    logic [31:0]        a_d;
    logic [31:0]        b_d;
    logic [1:0]         op_d;
    logic [CNT_W-1:0]   op_count_d;
    logic [31:0]        w_alu_y;
    logic               w_alu_zero;

    // w_grant is the requester id that would win if both are (or it is) valid.
    generate
        if (PRIO_MODE == 1) begin : g_prio_fixed
            assign w_grant = ~req0_valid;
        end else begin : g_prio_rr
            assign w_grant = (req0_valid & req1_valid) ? ~last_grant_q : ~req0_valid;
        end
    endgenerate

    assign w_idle     = (state_q == S_IDLE);
    assign req0_ready = w_idle & req0_valid & ~w_grant;
    assign req1_ready = w_idle & req1_valid &  w_grant;
    assign w_accept   = req0_ready | req1_ready;

    assign a_d        = w_grant ? req1_a  : req0_a;
    assign b_d        = w_grant ? req1_b  : req0_b;
    assign op_d       = w_grant ? req1_op : req0_op;
    assign op_count_d = op_count_q + CNT_W'(1);

    always_comb begin
        w_alu_y = 32'd0;
        case (op_q)
            c_OP_AND: w_alu_y = a_q & b_q;
            c_OP_OR:  w_alu_y = a_q | b_q;
            c_OP_ADD: w_alu_y = a_q + b_q;
            default:  w_alu_y = a_q - b_q;
        endcase
    end
    assign w_alu_zero = (w_alu_y == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            op_q         <= 2'b00;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= 32'd0;
            rsp_zero_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        a_q          <= a_d;
                        b_q          <= b_d;
                        op_q         <= op_d;
                        id_q         <= w_grant;
                        last_grant_q <= w_grant;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_y_q     <= w_alu_y;
                    rsp_zero_q  <= w_alu_zero;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    // Response is held indefinitely until the consumer takes it.
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = ~w_idle;
    assign op_count  = op_count_q;

endmodule
`default_nettype wire
